// File: rtl/rip_mem_access.sv
// rip-cpu memory-access stage: runs loads/stores over a valid/ready dmem port.
// Optional misaligned-access trap is enabled by defining RIP_MISALIGN_TRAP_EN.
module rip_mem_access #(
  parameter int XLEN          = 32,
  parameter bit SP_RESET_SAFE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd_num,
  input  logic            ex_reg_wen,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      ma_rd_num,
  output logic            wen,
  output logic [XLEN-1:0] wdata,
  output logic            misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      ld_rd_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            wen_q, mis_q, req_q, we_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wdata_q, addr_q, wd_q;
  logic [3:0]      strb_q;

  logic [1:0]      off;
  logic            is_mem, alu_wr, ld_wr, mis;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data, ld_shift, ld_val;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;

  assign off    = ex_alu_result[1:0];
  assign is_mem = ex_is_load | ex_is_store;
  assign alu_wr = ex_reg_wen && (!SP_RESET_SAFE || ex_rd_num != 5'd0);
  assign ld_wr  = !SP_RESET_SAFE || ld_rd_q != 5'd0;

  assign ex_ready       = (state_q == IDLE);
  assign wen            = wen_q;
  assign ma_rd_num      = rd_q;
  assign wdata          = wdata_q;
  assign misalign       = mis_q;
  assign dmem_req_valid = req_q;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_wstrb     = strb_q;
  assign dmem_wdata     = wd_q;

  // Misaligned halfword/word detection; zero when trapping is compiled out
  always_comb begin
`ifdef RIP_MISALIGN_TRAP_EN
    mis = is_mem && (
      (((ex_funct3 == 3'b001) || (ex_is_load && ex_funct3 == 3'b101)) && off[0]) ||
      ((ex_funct3 == 3'b010) && (off != 2'b00)));
`else
    mis = 1'b0;
`endif
  end

  // Store byte strobes and lane-replicated store data
  always_comb begin
    st_strb = 4'b1111;
    st_data = ex_store_data;
    case (ex_funct3)
      3'b000: begin
        st_strb = 4'b0001 << off;
        st_data = {4{ex_store_data[7:0]}};
      end
      3'b001: begin
        st_strb = 4'b0011 << {off[1], 1'b0};
        st_data = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
    if (ex_is_load) st_strb = 4'b0000;
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    ld_shift = dmem_rdata >> {off_q, 3'b000};
    ld_b     = ld_shift[7:0];
    ld_h     = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_b};
      3'b001:  ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_val = dmem_rdata;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_valid && is_mem && !mis) state_d = REQ;
      REQ:  if (dmem_req_ready) state_d = we_q ? IDLE : RESP;
      RESP: if (dmem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request fields and register-file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_rd_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid && !is_mem) begin
            if (alu_wr) begin
              wen_q   <= 1'b1;
              rd_q    <= ex_rd_num;
              wdata_q <= ex_alu_result;
            end
          end else if (ex_valid && mis) begin
            mis_q <= 1'b1;
          end else if (ex_valid) begin
            ld_rd_q <= ex_rd_num;
            f3_q    <= ex_funct3;
            off_q   <= off;
            req_q   <= 1'b1;
            addr_q  <= {ex_alu_result[XLEN-1:2], 2'b00};
            we_q    <= ex_is_store;
            strb_q  <= st_strb;
            wd_q    <= st_data;
          end
        end
        REQ: if (dmem_req_ready) req_q <= 1'b0;
        RESP: begin
          if (dmem_rsp_valid && ld_wr) begin
            wen_q   <= 1'b1;
            rd_q    <= ld_rd_q;
            wdata_q <= ld_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_mem_access.sv
// Scoreboard bench for rip_mem_access: random ALU/load/store stream
// checked against a byte-level memory model.
module tb_rip_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd_num = '0;
  logic        ex_reg_wen = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  ma_rd_num;
  logic        wen;
  logic [31:0] wdata;
  logic        misalign;

  always #5 clk = ~clk;

  rip_mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd_num(ex_rd_num), .ex_reg_wen(ex_reg_wen),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .ma_rd_num(ma_rd_num), .wen(wen), .wdata(wdata),
    .misalign(misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  req_t        rq[$];
  wr_t         wq[$];
  int          mq = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem[16];
  logic [31:0] dev_mem[16];
  bit          mem_en = 1'b1;
  int          stall_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm, logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", nm, act);
  endtask

  function automatic bit is_mis(bit ld, bit st, logic [2:0] f3, logic [1:0] off);
    bit r;
    r = 1'b0;
`ifdef RIP_MISALIGN_TRAP_EN
    if (ld || st) begin
      if ((f3 == 3'd1 || (ld && f3 == 3'd5)) && (off % 2 == 1)) r = 1'b1;
      if (f3 == 3'd2 && off != 0) r = 1'b1;
    end
`endif
    return r;
  endfunction

  // register-file write / misalign / busy monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wen) begin
          if (wq.size() == 0) flag("unexpected_wen", {27'd0, ma_rd_num});
          else begin
            w = wq.pop_front();
            chk("wen_rd", {27'd0, ma_rd_num}, {27'd0, w.rd});
            chk("wen_data", wdata, w.data);
          end
        end
        if (misalign) begin
          if (mq == 0) flag("unexpected_misalign", {31'd0, misalign});
          else mq--;
        end
        if (dmem_req_valid) chk("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
      end
    end
  end

  // memory device: random ready, stability, request compare, responses
  initial begin
    req_t pcap, cur, e;
    bit acc, prev_v, ld_out;
    int delay;
    logic [3:0] ridx;
    acc = 0; prev_v = 0; ld_out = 0; delay = 0; ridx = '0;
    forever begin
      @(negedge clk);
      if (!mem_en || !rst_n) begin
        acc = 0; prev_v = 0; ld_out = 0;
      end else begin
        dmem_rsp_valid = 1'b0;
        if (acc) begin
          if (rq.size() == 0) flag("unexpected_req", pcap.addr);
          else begin
            e = rq.pop_front();
            chk("req_addr", pcap.addr, e.addr);
            chk("req_we", {31'd0, pcap.we}, {31'd0, e.we});
            chk("req_wstrb", {28'd0, pcap.strb}, {28'd0, e.strb});
            if (e.we) chk("req_wdata", pcap.data, e.data);
          end
          if (pcap.we) begin
            for (int b = 0; b < 4; b++)
              if (pcap.strb[b]) dev_mem[pcap.addr[5:2]][8*b +: 8] = pcap.data[8*b +: 8];
          end else begin
            ld_out = 1; delay = $urandom_range(0, 3); ridx = pcap.addr[5:2];
          end
          prev_v = 0;
          acc = 0;
        end else if (ld_out) begin
          if (delay == 0) begin
            dmem_rsp_valid = 1'b1;
            dmem_rdata = dev_mem[ridx];
            ld_out = 0;
          end else delay--;
        end else if ($urandom_range(0, 7) == 0) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = $urandom;
        end
        if (dmem_req_valid) begin
          cur = '{addr: dmem_addr, we: dmem_we, strb: dmem_wstrb, data: dmem_wdata};
          if (prev_v) begin
            chk("hold_addr", cur.addr, pcap.addr);
            chk("hold_we", {31'd0, cur.we}, {31'd0, pcap.we});
            chk("hold_wstrb", {28'd0, cur.strb}, {28'd0, pcap.strb});
            chk("hold_wdata", cur.data, pcap.data);
          end
          pcap = cur;
          prev_v = 1;
          if (stall_cnt > 0) begin
            stall_cnt--;
            dmem_req_ready = 1'b0;
          end else dmem_req_ready = ($urandom_range(0, 2) != 0);
          acc = dmem_req_ready;
        end else begin
          prev_v = 0;
          acc = 0;
          dmem_req_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic issue(bit ld, bit st, logic [2:0] f3, logic [4:0] rd,
                       bit rw, logic [31:0] a, logic [31:0] sd);
    int budget;
    budget = 300;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_rd_num = rd; ex_reg_wen = rw; ex_alu_result = a; ex_store_data = sd;
    while (!ex_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!ex_ready) flag("issue_timeout", a);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // reference model: compute expected effects, then issue
  task automatic op(bit ld, bit st, logic [2:0] f3, logic [4:0] rd,
                    bit rw, logic [31:0] a, logic [31:0] sd);
    int off, idx;
    logic [31:0] w, b, h, v, strb, data;
    off = int'(a % 4);
    idx = int'((a / 4) % 16);
    if (!ld && !st) begin
      if (rw && rd != 0) wq.push_back('{rd: rd, data: a});
    end else if (is_mis(ld, st, f3, 2'(off))) begin
      mq++;
    end else if (st) begin
      if (f3 == 0) begin
        strb = 32'(1 << off); data = (sd % 256) * 32'h0101_0101;
      end else if (f3 == 1) begin
        strb = 32'(3 << (2 * (off / 2))); data = (sd % 65536) * 32'h0001_0001;
      end else begin
        strb = 15; data = sd;
      end
      for (int k = 0; k < 4; k++)
        if (strb[k]) ref_mem[idx][8*k +: 8] = data[8*k +: 8];
      rq.push_back('{addr: a - 32'(off), we: 1'b1, strb: strb[3:0], data: data});
    end else begin
      w = ref_mem[idx];
      b = (w >> (8 * off)) % 256;
      h = (w >> (16 * (off / 2))) % 65536;
      case (f3)
        3'd0:    v = (b >= 128) ? b - 256 : b;
        3'd4:    v = b;
        3'd1:    v = (h >= 32768) ? h - 65536 : h;
        3'd5:    v = h;
        default: v = w;
      endcase
      rq.push_back('{addr: a - 32'(off), we: 1'b0, strb: 4'd0, data: 32'd0});
      if (rd != 0) wq.push_back('{rd: rd, data: v});
    end
    issue(ld, st, f3, rd, rw, a, sd);
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((wq.size() != 0 || rq.size() != 0 || mq != 0 || !ex_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    chk("drain_wq", wq.size(), 0);
    chk("drain_rq", rq.size(), 0);
    chk("drain_mq", mq, 0);
  endtask

  initial begin
    int kind;
    logic [2:0] f3;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h80AA_BBCC;
    dev_mem[0] = 32'h80AA_BBCC;

    #12;
    chk("rst_wen", {31'd0, wen}, 0);
    chk("rst_rd", {27'd0, ma_rd_num}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_req_valid", {31'd0, dmem_req_valid}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_we", {31'd0, dmem_we}, 0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 0);
    chk("rst_dwdata", dmem_wdata, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 0, 3'd0, 5'd5, 1, 32'h1234_5678, 0);
    op(0, 0, 3'd0, 5'd0, 1, 32'hDEAD_BEEF, 0);
    op(0, 0, 3'd0, 5'd9, 1, 32'h0000_0042, 0);
    op(1, 0, 3'd0, 5'd3, 1, 32'h0000_1003, 0);
    op(1, 0, 3'd4, 5'd4, 1, 32'h0000_1003, 0);
    stall_cnt = 3;
    op(0, 1, 3'd1, 5'd0, 0, 32'h0000_2002, 32'h0000_BEEF);
    op(1, 0, 3'd2, 5'd6, 1, 32'h0000_3001, 0);
    drain();

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      if (kind < 4)
        op(0, 0, f3, 5'($urandom), 1'($urandom), $urandom, 0);
      else if (kind < 7)
        op(1, 0, f3, 5'($urandom), 1, $urandom, 0);
      else
        op(0, 1, ($urandom_range(0, 3) == 0) ? f3 : 3'($urandom_range(0, 2)),
           5'($urandom), 0, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();

    // reset in RESP abandons the load
    mem_en = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    issue(1, 0, 3'd2, 5'd7, 1, 32'h0000_1000, 0);
    @(negedge clk);
    chk("rr_req_valid", {31'd0, dmem_req_valid}, 1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rr_in_resp", {31'd0, ex_ready}, 0);
    rst_n = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rr_wen_low", {31'd0, wen}, 0);
    chk("rr_req_drop", {31'd0, dmem_req_valid}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("rr_ex_ready", {31'd0, ex_ready}, 1);
    chk("rr_wen_after", {31'd0, wen}, 0);
    mem_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rr_wq_empty", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
